// File: rtl/maple_tx_if.sv
// Byte handshake from the FX2 bridge plus Maple Bus pad signals.
interface maple_tx_if;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_read;
    logic       sdcka;
    logic       sdckb;
    logic       drive_en;
    logic       tx_busy;
    logic       frame_done;

    // Bridge / test side: supplies bytes, observes the bus.
    modport master (
        output tx_enable, tx_data,
        input  tx_read, sdcka, sdckb, drive_en, tx_busy, frame_done
    );

    // Serialiser side.
    modport slave (
        input  tx_enable, tx_data,
        output tx_read, sdcka, sdckb, drive_en, tx_busy, frame_done
    );
endinterface

// File: rtl/maple_tx.sv
// maple_tx: serialises bridge bytes onto the Maple Bus SDCKA/SDCKB pair with
// start pattern, alternating-clock data phases, optional XOR checksum and end pattern.
module maple_tx #(
    parameter int unsigned PHASE_CYCLES = 12,
    parameter int unsigned APPEND_CRC   = 1
) (
    input logic       clk,
    input logic       reset,
    maple_tx_if.slave bus
);
    localparam int unsigned CycW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StShift, StEnd} state_e;

    state_e          state_q, state_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [3:0]      tick_q, tick_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      xor_q, xor_d;
    logic            crc_sent_q, crc_sent_d;
    logic            tx_read_q, tx_read_d;
    logic            frame_done_q, frame_done_d;
    logic            drive_en_q, drive_en_d;
    logic            sdcka_q, sdcka_d;
    logic            sdckb_q, sdckb_d;
    logic            tick_end;
    logic [2:0]      bit_idx;
    logic            bit_val;

    assign tick_end = (cyc_q == CycLast);
    // Bit shown during the upcoming tick: two ticks per bit, MSB first.
    assign bit_idx  = 3'd7 - tick_d[3:1];
    assign bit_val  = shift_d[bit_idx];

    // Sequencer: tick counting, byte fetch at boundaries, checksum accumulation.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        tick_d       = tick_q;
        shift_d      = shift_q;
        xor_d        = xor_q;
        crc_sent_d   = crc_sent_q;
        drive_en_d   = drive_en_q;
        tx_read_d    = 1'b0;
        frame_done_d = 1'b0;

        if (state_q != StIdle) begin
            cyc_d = tick_end ? '0 : cyc_q + 1'b1;
            if (tick_end) begin
                tick_d = tick_q + 4'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tx_enable) begin
                    shift_d    = bus.tx_data;
                    xor_d      = bus.tx_data;
                    crc_sent_d = 1'b0;
                    tx_read_d  = 1'b1;
                    drive_en_d = 1'b1;
                    cyc_d      = '0;
                    tick_d     = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (tick_end && tick_q == 4'd10) begin
                    tick_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Byte boundary: next data byte wins over the checksum, else finish.
                if (tick_end && tick_q == 4'd15) begin
                    tick_d = '0;
                    if (bus.tx_enable) begin
                        shift_d   = bus.tx_data;
                        xor_d     = xor_q ^ bus.tx_data;
                        tx_read_d = 1'b1;
                    end else if (APPEND_CRC != 0 && !crc_sent_q) begin
                        shift_d    = xor_q;
                        crc_sent_d = 1'b1;
                    end else begin
                        state_d = StEnd;
                    end
                end
            end
            StEnd: begin
                if (tick_end && tick_q == 4'd5) begin
                    tick_d       = '0;
                    drive_en_d   = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line values for the tick being entered, so they register on its first edge.
    always_comb begin
        sdcka_d = 1'b1;
        sdckb_d = 1'b1;
        unique case (state_d)
            StIdle: begin
            end
            StStart: begin
                if (tick_d != 4'd0 && tick_d != 4'd10) begin
                    sdcka_d = 1'b0;
                    if (tick_d != 4'd1) begin
                        sdckb_d = tick_d[0];
                    end
                end
            end
            StShift: begin
                // First bit of each pair is clocked by A, second by B.
                if (!tick_d[1]) begin
                    sdcka_d = ~tick_d[0];
                    sdckb_d = bit_val;
                end else begin
                    sdckb_d = ~tick_d[0];
                    sdcka_d = bit_val;
                end
            end
            StEnd: begin
                if (tick_d != 4'd5) begin
                    sdcka_d = ~tick_d[0];
                    sdckb_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset abandons any frame without an end pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            tick_q       <= '0;
            shift_q      <= '0;
            xor_q        <= '0;
            crc_sent_q   <= 1'b0;
            tx_read_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drive_en_q   <= 1'b0;
            sdcka_q      <= 1'b1;
            sdckb_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            tick_q       <= tick_d;
            shift_q      <= shift_d;
            xor_q        <= xor_d;
            crc_sent_q   <= crc_sent_d;
            tx_read_q    <= tx_read_d;
            frame_done_q <= frame_done_d;
            drive_en_q   <= drive_en_d;
            sdcka_q      <= sdcka_d;
            sdckb_q      <= sdckb_d;
        end
    end

    assign bus.tx_read    = tx_read_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drive_en   = drive_en_q;
    assign bus.tx_busy    = drive_en_q;
    assign bus.sdcka      = sdcka_q;
    assign bus.sdckb      = sdckb_q;
endmodule
